ram_ctl: RTL and testbench

Parametrised byte-addressable data RAM for the MSP430 model, replacing the fixed 512-byte array. It is mapped into the 16-bit address space between `BOUND_L` and `BOUND_U` and supports word and byte access with MSP430 alignment rules. Reads have a registered, one-cycle latency. Out-of-range accesses are flagged, and an optional post-reset clear sequencer zeroes the array before the CPU may use it.

---
 rtl/ram_if.sv | 20 ++
 rtl/ram_ctl.sv | 103 ++++++++++
 tb/tb_ram_ctl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ram_if.sv
// ram_if: access bus between the CPU (master) and the data RAM (slave)
interface ram_if;
    logic        ram_en;
    logic [15:0] ram_addr;
    logic [15:0] ram_Din;
    logic        ram_RW;
    logic        BW;
    logic [15:0] ram_out;
    logic        ram_ready;
    logic        ram_err;
    logic        ram_busy;
    modport master (
        output ram_en, ram_addr, ram_Din, ram_RW, BW,
        input  ram_out, ram_ready, ram_err, ram_busy
    );
    modport slave (
        input  ram_en, ram_addr, ram_Din, ram_RW, BW,
        output ram_out, ram_ready, ram_err, ram_busy
    );
endinterface

// File: rtl/ram_ctl.sv
// ram_ctl: MSP430 data RAM mapped at [BOUND_L, BOUND_U), registered reads; RAM_CLEAR_ON_RESET_EN adds a post-reset clear sequencer
module ram_ctl #(
    parameter logic [15:0] BOUND_L = 16'h0200,
    parameter logic [15:0] BOUND_U = 16'h0400
) (
    input logic  clk,
    input logic  rst,
    ram_if.slave bus
);
    localparam int SIZE  = int'(BOUND_U - BOUND_L);
    localparam int WORDS = SIZE / 2;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [15:0]   mem_q [WORDS];
    logic          acc, hit, wr, rd, busy, clr_we;
    logic [IW:0]   off;
    logic [IW-1:0] idx, clr_idx;
    logic [15:0]   rword, rdata, out_q, out_d;
    logic          ready_q, ready_d, err_q, err_d;

    // Only the low IW+1 offset bits matter once the hit test has passed
    assign acc   = bus.ram_en & ~busy;
    assign hit   = (bus.ram_addr >= BOUND_L) && (bus.ram_addr < BOUND_U);
    assign off   = bus.ram_addr[IW:0] - BOUND_L[IW:0];
    assign idx   = off[IW:1];
    assign wr    = acc & hit & bus.ram_RW;
    assign rd    = acc & ~bus.ram_RW;
    assign rword = mem_q[idx];
    assign rdata = !hit ? 16'h0000 : bus.BW ? {8'h00, off[0] ? rword[15:8] : rword[7:0]} : rword;

`ifdef RAM_CLEAR_ON_RESET_EN
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;

    // State register: reset restarts the clear from word 0
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end

    // Next state: clear one word per cycle, leave after the last word
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + IW'(1);
            if (clr_idx_q == IW'(WORDS - 1))
                state_d = IDLE;
        end
    end

    // Outputs: busy blocks accesses while the sequencer owns the write port
    always_comb begin
        busy    = state_q == CLEAR;
        clr_we  = busy;
        clr_idx = clr_idx_q;
    end
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    // Memory write port: clear word or byte-lane write; a byte write to an odd offset lands in the high lane
    always_ff @(posedge clk)
        if (clr_we)
            mem_q[clr_idx] <= '0;
        else if (wr) begin
            if (!bus.BW || !off[0])
                mem_q[idx][7:0] <= bus.ram_Din[7:0];
            if (!bus.BW || off[0])
                mem_q[idx][15:8] <= bus.BW ? bus.ram_Din[7:0] : bus.ram_Din[15:8];
        end

    // Next output values: read data (zero when out of range) and status pulses
    always_comb begin
        out_d   = rd ? rdata : out_q;
        ready_d = rd;
        err_d   = acc & ~hit;
    end

    // Output registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end

    assign bus.ram_out   = out_q;
    assign bus.ram_ready = ready_q;
    assign bus.ram_err   = err_q;
    assign bus.ram_busy  = busy;
endmodule

// File: tb/tb_ram_ctl.sv
// tb_ram_ctl: directed self-checking bench for ram_ctl
module tb_ram_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;

    ram_if bus();
    ram_ctl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic acc(input logic rw, input logic bw, input logic [15:0] a, input logic [15:0] d);
        bus.ram_en   = 1'b1;
        bus.ram_RW   = rw;
        bus.BW       = bw;
        bus.ram_addr = a;
        bus.ram_Din  = d;
        @(posedge clk);
        @(negedge clk);
        bus.ram_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic bw, input logic [15:0] a,
                          input logic [15:0] exp, input logic err);
        acc(1'b0, bw, a, 16'h0000);
        check({tag, "_out"}, bus.ram_out, exp);
        check({tag, "_rdy"}, bus.ram_ready, 1);
        check({tag, "_err"}, bus.ram_err, err);
    endtask

    task automatic wr_chk(input string tag, input logic bw, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] hold, input logic err);
        acc(1'b1, bw, a, d);
        check({tag, "_hold"}, bus.ram_out, hold);
        check({tag, "_rdy"}, bus.ram_ready, 0);
        check({tag, "_err"}, bus.ram_err, err);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        check({tag, "_rdy"}, bus.ram_ready, 0);
        check({tag, "_err"}, bus.ram_err, 0);
    endtask

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (bus.ram_busy && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        bus.ram_en   = 1'b0;
        bus.ram_RW   = 1'b0;
        bus.BW       = 1'b0;
        bus.ram_addr = 16'h0000;
        bus.ram_Din  = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_out", bus.ram_out, 0);
        check("rst_rdy", bus.ram_ready, 0);
        check("rst_err", bus.ram_err, 0);
`ifdef RAM_CLEAR_ON_RESET_EN
        check("rst_busy", bus.ram_busy, 1);
        rst = 1'b0;
        n = 0;
        while (bus.ram_busy && n < 2000) begin
            bus.ram_en   = (n == 50 || n == 60);
            bus.ram_RW   = (n == 50);
            bus.ram_addr = (n == 50) ? 16'h0200 : 16'h0100;
            bus.ram_Din  = 16'hFFFF;
            @(negedge clk);
            n++;
            if (n == 51 || n == 61) begin
                check("busy_rdy", bus.ram_ready, 0);
                check("busy_err", bus.ram_err, 0);
            end
        end
        bus.ram_en = 1'b0;
        check("clr_len", n, 256);
        rd_chk("clr_lo", 1'b0, 16'h0200, 16'h0000, 1'b0);
        rd_chk("clr_hi", 1'b0, 16'h03FE, 16'h0000, 1'b0);
        acc(1'b1, 1'b0, 16'h0200, 16'h5555);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_clear(n);
        check("reclr_len", n, 256);
        rd_chk("reclr", 1'b0, 16'h0200, 16'h0000, 1'b0);
`else
        check("rst_busy", bus.ram_busy, 0);
        rst = 1'b0;
        @(negedge clk);
`endif
        // Word/byte mix
        wr_chk("w_beef", 1'b0, 16'h0210, 16'hBEEF, bus.ram_out, 1'b0);
        wr_chk("b_5a", 1'b1, 16'h0211, 16'h775A, bus.ram_out, 1'b0);
        rd_chk("mix_w", 1'b0, 16'h0210, 16'h5AEF, 1'b0);
        rd_chk("mix_b0", 1'b1, 16'h0210, 16'h00EF, 1'b0);
        rd_chk("mix_b1", 1'b1, 16'h0211, 16'h005A, 1'b0);
        // Alignment
        wr_chk("w_odd", 1'b0, 16'h0221, 16'h1234, 16'h005A, 1'b0);
        rd_chk("al_b0", 1'b1, 16'h0220, 16'h0034, 1'b0);
        rd_chk("al_b1", 1'b1, 16'h0221, 16'h0012, 1'b0);
        rd_chk("al_w", 1'b0, 16'h0220, 16'h1234, 1'b0);
        wr_chk("w_top", 1'b0, 16'h03FE, 16'hABCD, 16'h1234, 1'b0);
        rd_chk("top_odd", 1'b0, 16'h03FF, 16'hABCD, 1'b0);
        wr_chk("w_base", 1'b0, 16'h0200, 16'h1111, 16'hABCD, 1'b0);
        // Range
        rd_chk("oob_lo", 1'b0, 16'h01FF, 16'h0000, 1'b1);
        idle_chk("oob_lo_pulse");
        rd_chk("base", 1'b0, 16'h0200, 16'h1111, 1'b0);
        rd_chk("oob_hi", 1'b0, 16'h0400, 16'h0000, 1'b1);
        idle_chk("oob_hi_pulse");
        wr_chk("oob_wr", 1'b0, 16'h0400, 16'hFFFF, 16'h0000, 1'b1);
        wr_chk("oob_wrb", 1'b1, 16'h01FF, 16'hFFFF, 16'h0000, 1'b1);
        rd_chk("keep_base", 1'b0, 16'h0200, 16'h1111, 1'b0);
        rd_chk("keep_top", 1'b0, 16'h03FE, 16'hABCD, 1'b0);
        rd_chk("oob_b", 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        // Streaming reads
        for (int i = 0; i < 8; i++)
            acc(1'b1, 1'b0, 16'h0300 + 16'(2 * i), 16'hC000 + 16'(i));
        check("pre_stream_rdy", bus.ram_ready, 0);
        for (int i = 0; i < 8; i++) begin
            bus.ram_en   = 1'b1;
            bus.ram_RW   = 1'b0;
            bus.BW       = 1'b0;
            bus.ram_addr = 16'h0300 + 16'(2 * i);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stream%0d_rdy", i), bus.ram_ready, 1);
            check($sformatf("stream%0d_out", i), bus.ram_out, 16'hC000 + 16'(i));
        end
        bus.ram_en = 1'b0;
        idle_chk("stream_end");
        // Reset right after a read was accepted
        bus.ram_en   = 1'b1;
        bus.ram_RW   = 1'b0;
        bus.ram_addr = 16'h0210;
        @(posedge clk);
        #1;
        check("mid_rdy_pre", bus.ram_ready, 1);
        rst = 1'b1;
        #1;
        check("mid_rdy", bus.ram_ready, 0);
        check("mid_out", bus.ram_out, 0);
        check("mid_err", bus.ram_err, 0);
        bus.ram_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
